// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: data width, default depth
// and the launch FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned TXQ_DEPTH   = 16;

    typedef enum logic [1:0] {
        TXQ_IDLE   = 2'd0,
        TXQ_LAUNCH = 2'd1,
        TXQ_WAIT   = 2'd2
    } txq_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO: storage, read/write pointers, occupancy count and
// registered empty/full flags. DEPTH must be a power of two so the pointers
// wrap naturally at DEPTH-1 -> 0.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = TXQ_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic              push_en;
    logic              pop_en;

    // Qualify requests against current flags and compute next pointers/count.
    always_comb begin
        push_en  = push & ~full_q;
        pop_en   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr_q];
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus launch controller feeding the UART transmitter through the
// tx_start / tx_data_in / tx_busy / tx_done handshake.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = TXQ_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    input  logic              ovf_clr
);

    logic [DATA_W-1:0] fifo_rd_data;
    logic              pop_c;

    txq_state_e        state_q,    state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_busy_q;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .wr_data   (wr_data),
        .pop       (pop_c),
        .rd_data_c (fifo_rd_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Acceptance depends only on registered occupancy, never on a same-cycle pop.
    assign wr_ready = ~full;

    // Launch FSM next-state: pop in IDLE, hold start until the transmitter
    // reports busy, then wait for end of frame.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop_c      = 1'b0;
        case (state_q)
            TXQ_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop_c      = 1'b1;
                    tx_data_d  = fifo_rd_data;
                    tx_start_d = 1'b1;
                    state_d    = TXQ_LAUNCH;
                end
            end
            TXQ_LAUNCH: begin
                if (tx_done) begin
                    tx_start_d = 1'b0;
                    state_d    = TXQ_IDLE;
                end else if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = TXQ_WAIT;
                end
            end
            TXQ_WAIT: begin
                if (tx_done || (tx_busy_q && !tx_busy)) begin
                    state_d = TXQ_IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = TXQ_IDLE;
            end
        endcase
    end

    // Launch FSM state and registered transmitter-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= TXQ_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data_in = tx_data_q;

`ifdef UART_TXQ_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a write attempt while full sets it and wins over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: randomized host writes, a behavioural
// transmitter, and a scoreboard of bytes expected on the serial side.
module tb_uart_tx_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data_in;
    logic          tx_busy;
    logic          tx_done  = 1'b0;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          ovf_clr  = 1'b0;

    logic          m_busy   = 1'b0;
    logic          ext_busy = 1'b0;
    int            frame_len = 3;
    int            bit_cnt   = 0;
    logic [DW-1:0] cur_byte  = '0;

    logic [DW-1:0] sb[$];
    int            exp_cnt    = 0;
    logic          pend_push  = 1'b0;
    logic          prev_start = 1'b0;
    logic          pend_set   = 1'b0;
    logic          pend_clr   = 1'b0;
    logic          exp_ovf    = 1'b0;

    int checks = 0;
    int errors = 0;

    assign tx_busy = m_busy | ext_busy;

    always #5 clk = ~clk;

    uart_tx_queue dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + transmitter model: occupancy model, overflow model, scoreboard pops.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_busy     = 1'b0;
            tx_done    = 1'b0;
            bit_cnt    = 0;
            exp_cnt    = 0;
            pend_push  = 1'b0;
            prev_start = 1'b0;
            pend_set   = 1'b0;
            pend_clr   = 1'b0;
            exp_ovf    = 1'b0;
        end else begin
            if (pend_push) exp_cnt++;
            if (tx_start && !prev_start) exp_cnt--;
`ifdef UART_TXQ_OVF_EN
            if (pend_set) exp_ovf = 1'b1;
            else if (pend_clr) exp_ovf = 1'b0;
`endif
            prev_start = tx_start;
            chk("count", 32'(count), 32'(exp_cnt));
            chk("empty", 32'(empty), 32'(exp_cnt == 0));
            chk("full", 32'(full), 32'(exp_cnt == DEPTH));
            chk("wr_ready", 32'(wr_ready), 32'(exp_cnt != DEPTH));
            chk("ovf", 32'(ovf), 32'(exp_ovf));

            tx_done = 1'b0;
            if (m_busy) begin
                chk("tx_data_stable", 32'(tx_data_in), 32'(cur_byte));
                bit_cnt--;
                if (bit_cnt <= 0) begin
                    m_busy  = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tx_launch_unexpected actual=%0h required=none", tx_data_in);
                end else begin
                    logic [DW-1:0] exp_b;
                    exp_b = sb.pop_front();
                    if (tx_data_in !== exp_b) begin
                        errors++;
                        $display("FAIL tx_order actual=%0h required=%0h", tx_data_in, exp_b);
                    end
                end
                cur_byte = tx_data_in;
                m_busy   = 1'b1;
                bit_cnt  = frame_len;
            end

            pend_push = wr_valid && wr_ready;
            if (pend_push) sb.push_back(wr_data);
            pend_set = wr_valid && full;
            pend_clr = ovf_clr;
        end
    end

    task automatic push_one(input logic [DW-1:0] d);
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 3000 && !(sb.size() == 0 && !m_busy && !tx_start && empty)) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", 32'(n < 3000), 32'(1));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic exp_ovf_const;
        int   sent;
        int   guard;
`ifdef UART_TXQ_OVF_EN
        exp_ovf_const = 1'b1;
`else
        exp_ovf_const = 1'b0;
`endif
        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data_in), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_tx_start", 32'(tx_start), 0);
        end

        // Single byte with latency check
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("lat_start_n", 32'(tx_start), 0);
        chk("lat_empty_n", 32'(empty), 0);
        @(negedge clk);
        chk("lat_start_n1", 32'(tx_start), 1);
        chk("lat_data", 32'(tx_data_in), 32'h0A5);
        @(negedge clk);
        chk("start_drop", 32'(tx_start), 0);
        drain();

        // Burst fill while the transmitter is held busy externally
        @(posedge clk); #1;
        ext_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("burst_count", 32'(count), 32'(DEPTH));
        chk("burst_full", 32'(full), 1);
        chk("burst_wr_ready", 32'(wr_ready), 0);
        chk("burst_no_start", 32'(tx_start), 0);
        push_one(8'hFF);
        @(negedge clk);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_set", 32'(ovf), 32'(exp_ovf_const));
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        ovf_clr  = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", 32'(ovf), 32'(exp_ovf_const));
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(ovf), 0);
        @(posedge clk); #1;
        ext_busy = 1'b0;
        drain();
        chk("burst_drained", 32'(count), 0);

        // Randomized sustained traffic; 40 bytes wrap the pointers twice
        sent  = 0;
        guard = 0;
        while (sent < 40 && guard < 4000) begin
            @(posedge clk); #1;
            frame_len = int'($urandom_range(1, 4));
            wr_valid  = ($urandom_range(0, 2) != 0);
            wr_data   = DW'($urandom);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            if (wr_valid && wr_ready) sent++;
            guard++;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        chk("random_sent", 32'(sent), 40);
        drain();

        // Reset in the middle of a long frame with bytes still queued
        frame_len = 40;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h50 + i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        guard = 0;
        while (guard < 100 && !(m_busy && count == 5)) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("mid_wait", 32'(guard < 100), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_start", 32'(tx_start), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_data", 32'(tx_data_in), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        frame_len = 3;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_no_launch", 32'(tx_start), 0);
        end
        push_one(8'h3C);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue with launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a host over a valid/ready write port and buffers them in a synchronous FIFO.
- Launches one byte at a time into the transmitter through its tx_start / tx_data_in / tx_busy / tx_done handshake.
- Lets software burst up to DEPTH bytes without polling tx_busy.

Parameters:
DATA_W, 8, byte width; must match the transmitter data width
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; occupancy count uses ADDR_W+1 bits

Ports:
clk  input  1  system clock; the only clock
rst  input  1  asynchronous, active-low reset
wr_valid  input  1  host offers a byte
wr_data  input  DATA_W  host byte
wr_ready  output  1  queue can accept; equals !full
tx_start  output  1  launch request to transmitter
tx_data_in  output  DATA_W  byte presented to transmitter
tx_busy  input  1  transmitter is shifting a frame
tx_done  input  1  one-cycle pulse at end of frame
count  output  ADDR_W+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
ovf  output  1  sticky overflow flag (see Optional Feature)
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst low, asynchronous): pointers=0, count=0, empty=1, full=0, wr_ready=1, tx_start=0, tx_data_in=0, ovf=0, FSM=IDLE. Reset mid-frame discards all queued bytes and drops tx_start immediately.
- Push: occurs on an edge where wr_valid & wr_ready; writes mem[wr_ptr], then wr_ptr++ with wrap at DEPTH-1->0.
- Full: wr_ready=0 and the byte is dropped. A pop in the same cycle does not re-enable acceptance; wr_ready is purely registered-state based.
- Pop: performed only by the FSM in IDLE. tx_data_in is loaded from mem[rd_ptr] on the same edge, then rd_ptr++ with wrap.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into an empty FIFO is never bypassed; the byte must be visible in count before it can pop.
- Latency: byte accepted at edge N -> empty=0 after N -> pop at edge N+1 -> tx_start=1 in cycle after N+1.
- FSM states:
  - IDLE: if !empty & !tx_busy -> pop, load tx_data_in, tx_start<=1 -> LAUNCH.
  - LAUNCH: hold tx_start=1 until tx_busy sampled 1 -> tx_start<=0 -> WAIT. If tx_done is sampled in LAUNCH (very short frame), go straight to IDLE with tx_start<=0.
  - WAIT: tx_start=0 -> on tx_done=1 or tx_busy falling -> IDLE.
- tx_data_in is held stable from LAUNCH entry until the next pop. It is never changed while tx_busy=1.
- Back-to-back: from tx_done the next tx_start asserts 2 cycles later, in the cycle after IDLE pops.
- External tx_busy=1 while in IDLE (another master) blocks the pop; nothing is lost.
- count: ADDR_W+1 bits, increments or decrements by at most 1 per cycle, never wraps.

Optional Feature:
- Macro UART_TXQ_OVF_EN.
- Defined: ovf sets to 1 on any edge with wr_valid & full. It stays set until ovf_clr=1. If set and clear occur on the same edge, set wins.
- Undefined: ovf is tied 0, ovf_clr is ignored, and there is no overflow logic.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (TXQ_IDLE, TXQ_LAUNCH, TXQ_WAIT)
  - UART_DATA_W=8
  - default TXQ_DEPTH=16
- One sub-module, uart_sync_fifo (storage, pointers, count, flags).
- uart_tx_queue instantiates it plus the launch FSM.

Test Plan:
- Reset then idle: after rst released, expect empty=1, count=0, wr_ready=1, tx_start=0, tx_data_in=0; tx_busy held 0 for 20 cycles -> tx_start stays 0.
- Single byte: push 0xA5 at edge N with transmitter model -> tx_start=1 in cycle after N+1, tx_data_in=0xA5 stable until tx_done; tx_start drops the cycle after tx_busy=1.
- Burst fill: push 16 bytes 0x00..0x0F while tx_busy=1 -> count=16, full=1, wr_ready=0; serial output order 0x00..0x0F; count returns to 0.
- Overflow (UART_TXQ_OVF_EN): push 17th byte 0xFF while full -> byte dropped, ovf=1 until ovf_clr pulse; simultaneous push-while-full and ovf_clr -> ovf stays 1. Without macro -> ovf=0 throughout.
- Wrap/simultaneous: sustain push and pop every frame for 40 bytes -> pointers wrap twice, count constant, no reorder or loss.
- Reset mid-frame: assert rst low during WAIT with 5 queued -> tx_start=0, count=0 immediately; after release, no launch until a new push.
